// File: rtl/mips_defs.sv
// Shared MIPS decode constants for the pipeline.
// Contents: opcode and funct field values, well-known register numbers,
// and the write-back source select type.
package mips_defs;

  // Primary opcodes (InstrW[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  // R-type funct codes (InstrW[5:0])
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_MOVZ    = 6'h0A;
  localparam logic [5:0] FN_MOVN    = 6'h0B;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADDU    = 6'h21;

  // Register numbers
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_GP   = 5'd28;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [2:0] {
    SrcAlu,
    SrcLoad,
    SrcPc8,
    SrcHi,
    SrcLo
  } wb_src_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_LH) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/load_ext.sv
// Sub-word load extraction and extension.
// Ports:
//   ReadDataW  in  32  raw data-memory word
//   off        in  2   byte offset of the load address
//   op         in  6   primary opcode of the load
//   ExtData    out 32  selected and extended load value
// Non-load opcodes pass the word through unchanged, same as lw.
module load_ext
  import mips_defs::*;
(
  input  logic [31:0] ReadDataW,
  input  logic [1:0]  off,
  input  logic [5:0]  op,
  output logic [31:0] ExtData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = ReadDataW[7:0];
    unique case (off)
      2'd0: w_byte = ReadDataW[7:0];
      2'd1: w_byte = ReadDataW[15:8];
      2'd2: w_byte = ReadDataW[23:16];
      2'd3: w_byte = ReadDataW[31:24];
      default: w_byte = ReadDataW[7:0];
    endcase
  end

  // Halfword select ignores off[0]; misaligned halfwords are not trapped here.
  assign w_half = off[1] ? ReadDataW[31:16] : ReadDataW[15:0];

  always_comb begin
    ExtData = ReadDataW;
    case (op)
      OP_LB:   ExtData = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  ExtData = {24'h0, w_byte};
      OP_LH:   ExtData = {{16{w_half[15]}}, w_half};
      OP_LHU:  ExtData = {16'h0, w_half};
      default: ExtData = ReadDataW;
    endcase
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// MIPS write-back stage plus 32x32 general-purpose register file.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   InstrW, WriteRegW          instruction in W (0 = bubble), destination register
//   PCouter8W, ReadDataW,      write-back source candidates
//   ALUOutW, HiDataW, LoDataW  (ALUOutW[1:0] is also the load byte offset)
//   RtDataW, movnW, movzW      MOVN/MOVZ condition inputs
//   A1/RD1, A2/RD2             decode read ports, combinational with write-through
//   RegWriteW, WriteDataW      qualified write enable and value, for forwarding
//   RetiredCnt                 count of non-bubble instructions leaving W
module wb_stage_regfile
  import mips_defs::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter logic [31:0] GP_INIT = 32'h0000_1800,
  parameter logic [31:0] SP_INIT = 32'h0000_2FFC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      InstrW,
  input  logic [4:0]       WriteRegW,
  input  logic [31:0]      PCouter8W,
  input  logic [31:0]      ReadDataW,
  input  logic [31:0]      ALUOutW,
  input  logic [31:0]      HiDataW,
  input  logic [31:0]      LoDataW,
  input  logic [31:0]      RtDataW,
  input  logic             movnW,
  input  logic             movzW,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  output logic             RegWriteW,
  output logic [31:0]      WriteDataW,
  output logic [CNT_W-1:0] RetiredCnt
);

  logic [31:0]      r_gpr [32];
  logic [CNT_W-1:0] r_cnt;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_writer;
  logic        w_cond;
  logic        w_bubble;
  wb_src_e     w_src;
  logic [31:0] w_load_data;
  logic        unused_instr;

  assign w_op         = InstrW[31:26];
  assign w_funct      = InstrW[5:0];
  assign w_bubble     = (InstrW == 32'h0);
  assign unused_instr = ^InstrW[25:6];

  load_ext u_load_ext (
    .ReadDataW (ReadDataW),
    .off       (ALUOutW[1:0]),
    .op        (w_op),
    .ExtData   (w_load_data)
  );

  // Writer class and write-back source decode.
  always_comb begin
    w_writer = 1'b0;
    w_src    = SrcAlu;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
          FN_MTHI, FN_MTLO, FN_SYSCALL: w_writer = 1'b0;
          default:                      w_writer = 1'b1;
        endcase
        case (w_funct)
          FN_JALR: w_src = SrcPc8;
          FN_MFHI: w_src = SrcHi;
          FN_MFLO: w_src = SrcLo;
          default: w_src = SrcAlu;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_writer = 1'b1;
      OP_JAL: begin
        w_writer = 1'b1;
        w_src    = SrcPc8;
      end
      default: begin
        if (is_load(w_op)) begin
          w_writer = 1'b1;
          w_src    = SrcLoad;
        end
      end
    endcase
  end

  always_comb begin
    WriteDataW = ALUOutW;
    unique case (w_src)
      SrcLoad: WriteDataW = w_load_data;
      SrcPc8:  WriteDataW = PCouter8W;
      SrcHi:   WriteDataW = HiDataW;
      SrcLo:   WriteDataW = LoDataW;
      default: WriteDataW = ALUOutW;
    endcase
  end

  // MOVN and MOVZ together is illegal and suppresses the write.
  always_comb begin
    w_cond = 1'b1;
    if (movnW && movzW) begin
      w_cond = 1'b0;
    end else if (movnW) begin
      w_cond = (RtDataW != 32'h0);
    end else if (movzW) begin
      w_cond = (RtDataW == 32'h0);
    end
  end

  // A bubble decodes as sll $0; gating it explicitly keeps it harmless
  // even if WriteRegW carries stale bits.
  assign RegWriteW = w_writer && (WriteRegW != REG_ZERO) && w_cond && !w_bubble;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        if (i == int'(REG_GP)) begin
          r_gpr[i] <= GP_INIT;
        end else if (i == int'(REG_SP)) begin
          r_gpr[i] <= SP_INIT;
        end else begin
          r_gpr[i] <= 32'h0;
        end
      end
    end else if (RegWriteW) begin
      r_gpr[WriteRegW] <= WriteDataW;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!w_bubble) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign RetiredCnt = r_cnt;

  // Write-through so decode sees the value committing this cycle.
  assign RD1 = (RegWriteW && (A1 == WriteRegW)) ? WriteDataW : r_gpr[A1];
  assign RD2 = (RegWriteW && (A2 == WriteRegW)) ? WriteDataW : r_gpr[A2];

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for wb_stage_regfile, built with a 4-bit retired counter
// so that wrap-around is reached after 16 instructions.
module tb_wb_stage_regfile;
  import mips_defs::*;

  logic        clk;
  logic        reset;
  logic [31:0] InstrW;
  logic [4:0]  WriteRegW;
  logic [31:0] PCouter8W;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [31:0] HiDataW;
  logic [31:0] LoDataW;
  logic [31:0] RtDataW;
  logic        movnW;
  logic        movzW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        RegWriteW;
  logic [31:0] WriteDataW;
  logic [3:0]  RetiredCnt;

  int checks   = 0;
  int failures = 0;

  wb_stage_regfile #(
    .CNT_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .InstrW     (InstrW),
    .WriteRegW  (WriteRegW),
    .PCouter8W  (PCouter8W),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .HiDataW    (HiDataW),
    .LoDataW    (LoDataW),
    .RtDataW    (RtDataW),
    .movnW      (movnW),
    .movzW      (movzW),
    .A1         (A1),
    .A2         (A2),
    .RD1        (RD1),
    .RD2        (RD2),
    .RegWriteW  (RegWriteW),
    .WriteDataW (WriteDataW),
    .RetiredCnt (RetiredCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 26'h0};
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    InstrW = 32'h0;
    movnW  = 1'b0;
    movzW  = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b0; InstrW = 32'h0; WriteRegW = 5'd0; PCouter8W = 32'h0;
    ReadDataW = 32'h0; ALUOutW = 32'h0; HiDataW = 32'h0; LoDataW = 32'h0;
    RtDataW = 32'h0; movnW = 1'b0; movzW = 1'b0; A1 = 5'd0; A2 = 5'd0;
    repeat (2) tick();
    reset = 1'b1;
    #1;

    // Reset values
    A1 = 5'd28; A2 = 5'd29; #1;
    chk("rst_gp", RD1, 32'h0000_1800);
    chk("rst_sp", RD2, 32'h0000_2FFC);
    A1 = 5'd5; #1;
    chk("rst_r5", RD1, 32'h0);
    chk("rst_cnt", {28'h0, RetiredCnt}, 32'h0);

    // lb $8, off 1
    InstrW = itype(OP_LB); WriteRegW = 5'd8; ReadDataW = 32'h1234_80FF; ALUOutW = 32'h1;
    #1;
    chk("lb_we", {31'h0, RegWriteW}, 32'h1);
    chk("lb_wd", WriteDataW, 32'hFFFF_FF80);
    tick(); bubble();
    A1 = 5'd8; #1;
    chk("lb_r8", RD1, 32'hFFFF_FF80);
    chk("lb_cnt", {28'h0, RetiredCnt}, 32'h1);

    // lbu $10, off 1
    InstrW = itype(OP_LBU); WriteRegW = 5'd10; #1;
    tick(); bubble();
    A1 = 5'd10; #1;
    chk("lbu_r10", RD1, 32'h0000_0080);

    // lh $11, off 2
    InstrW = itype(OP_LH); WriteRegW = 5'd11; ALUOutW = 32'h2; #1;
    tick(); bubble();
    A1 = 5'd11; #1;
    chk("lh_r11", RD1, 32'h0000_1234);
    chk("lh_cnt", {28'h0, RetiredCnt}, 32'h3);

    // jal with write-through on port 1
    InstrW = itype(OP_JAL); WriteRegW = 5'd31; PCouter8W = 32'h3008; A1 = 5'd31; A2 = 5'd31;
    #1;
    chk("jal_wt1", RD1, 32'h3008);
    chk("jal_wt2", RD2, 32'h3008);
    tick(); bubble();
    chk("jal_r31", RD1, 32'h3008);

    // movn $9 with rt == 0: squashed but retired
    InstrW = rtype(FN_MOVN); movnW = 1'b1; WriteRegW = 5'd9; RtDataW = 32'h0;
    ALUOutW = 32'hAB; A1 = 5'd9; #1;
    chk("movn0_we", {31'h0, RegWriteW}, 32'h0);
    tick(); bubble();
    chk("movn0_r9", RD1, 32'h0);
    chk("movn0_cnt", {28'h0, RetiredCnt}, 32'h5);

    // movn $9 with rt != 0
    InstrW = rtype(FN_MOVN); movnW = 1'b1; RtDataW = 32'h5; #1;
    chk("movn1_we", {31'h0, RegWriteW}, 32'h1);
    tick(); bubble();
    chk("movn1_r9", RD1, 32'hAB);

    // movz $12 with rt == 0 writes
    InstrW = rtype(FN_MOVZ); movzW = 1'b1; WriteRegW = 5'd12; RtDataW = 32'h0;
    ALUOutW = 32'h77; A1 = 5'd12; #1;
    chk("movz_we", {31'h0, RegWriteW}, 32'h1);
    tick(); bubble();
    chk("movz_r12", RD1, 32'h77);

    // movn and movz together: no write
    InstrW = rtype(FN_MOVN); movnW = 1'b1; movzW = 1'b1; WriteRegW = 5'd13; A1 = 5'd13; #1;
    chk("both_we", {31'h0, RegWriteW}, 32'h0);
    tick(); bubble();
    chk("both_r13", RD1, 32'h0);
    chk("both_cnt", {28'h0, RetiredCnt}, 32'h8);

    // addu to $0
    InstrW = rtype(FN_ADDU); WriteRegW = 5'd0; ALUOutW = 32'hDEAD; A1 = 5'd0; #1;
    chk("r0_we", {31'h0, RegWriteW}, 32'h0);
    chk("r0_rd", RD1, 32'h0);
    tick(); bubble();
    chk("r0_after", RD1, 32'h0);

    // Bubble with a stale destination
    WriteRegW = 5'd14; ALUOutW = 32'h55; A1 = 5'd14; #1;
    chk("bub_we", {31'h0, RegWriteW}, 32'h0);
    tick();
    chk("bub_r14", RD1, 32'h0);
    chk("bub_cnt", {28'h0, RetiredCnt}, 32'h9);

    // mfhi $15, mflo $16
    InstrW = rtype(FN_MFHI); WriteRegW = 5'd15; HiDataW = 32'h1111; LoDataW = 32'h2222; #1;
    tick(); bubble();
    InstrW = rtype(FN_MFLO); WriteRegW = 5'd16; #1;
    tick(); bubble();
    A1 = 5'd15; A2 = 5'd16; #1;
    chk("mfhi_r15", RD1, 32'h1111);
    chk("mflo_r16", RD2, 32'h2222);

    // mult is not a writer
    InstrW = rtype(FN_MULT); WriteRegW = 5'd17; #1;
    chk("mult_we", {31'h0, RegWriteW}, 32'h0);
    tick(); bubble();

    // lw off 3 passes the word
    InstrW = itype(OP_LW); WriteRegW = 5'd18; ReadDataW = 32'hCAFE_BABE; ALUOutW = 32'h3; #1;
    chk("lw_wd", WriteDataW, 32'hCAFE_BABE);
    tick(); bubble();

    // lh off 1 uses the low halfword
    InstrW = itype(OP_LH); WriteRegW = 5'd19; ReadDataW = 32'h0000_8001; ALUOutW = 32'h1; #1;
    chk("lh1_wd", WriteDataW, 32'hFFFF_8001);
    tick(); bubble();
    chk("pre_wrap_cnt", {28'h0, RetiredCnt}, 32'he);

    InstrW = rtype(FN_ADDU); WriteRegW = 5'd20; ALUOutW = 32'h5; #1;
    tick();
    chk("cnt_f", {28'h0, RetiredCnt}, 32'hf);
    WriteRegW = 5'd21; #1;
    tick(); bubble();
    chk("cnt_wrap", {28'h0, RetiredCnt}, 32'h0);

    // Overwrite $28, then reset asynchronously mid-run
    InstrW = rtype(FN_ADDU); WriteRegW = 5'd28; ALUOutW = 32'hAAAA; #1;
    tick(); bubble();
    A2 = 5'd28; #1;
    chk("gp_wr", RD2, 32'hAAAA);
    InstrW = rtype(FN_ADDU); WriteRegW = 5'd8; ALUOutW = 32'h999; A1 = 5'd10; A2 = 5'd28;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_cnt", {28'h0, RetiredCnt}, 32'h0);
    chk("arst_r10", RD1, 32'h0);
    chk("arst_gp", RD2, 32'h0000_1800);
    tick();
    reset = 1'b1;
    bubble();
    A1 = 5'd8; #1;
    chk("arst_r8", RD1, 32'h0);
    chk("arst_cnt2", {28'h0, RetiredCnt}, 32'h0);

    // First commit after release
    InstrW = rtype(FN_ADDU); WriteRegW = 5'd8; ALUOutW = 32'h42; #1;
    tick(); bubble();
    chk("post_r8", RD1, 32'h42);
    chk("post_cnt", {28'h0, RetiredCnt}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage_regfile.md
Name: wb_stage_regfile

Overview:
- Write-back stage of the five-stage MIPS pipeline; consumes the M/W pipeline register outputs.
- Selects the write-back value (load data, ALU result, PC+8, HI, LO) and extends sub-word loads.
- Applies MOVN/MOVZ conditions and commits the result to the 32x32 GPR file.
- The GPR file has two decode-stage read ports with write-through, plus a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- GP_INIT, 32'h0000_1800, reset value of $28.
- SP_INIT, 32'h0000_2FFC, reset value of $29.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- InstrW  in  32  instruction in W; 32'h0 marks a bubble.
- WriteRegW  in  5  destination register number.
- PCouter8W  in  32  PC+8 of the instruction.
- ReadDataW  in  32  raw data-memory word.
- ALUOutW  in  32  ALU result; also the load address, [1:0] is the byte offset.
- HiDataW  in  32  HI value.
- LoDataW  in  32  LO value.
- RtDataW  in  32  rt operand for the MOVN/MOVZ condition.
- movnW  in  1  instruction is MOVN.
- movzW  in  1  instruction is MOVZ.
- A1  in  5  read address, port 1.
- A2  in  5  read address, port 2.
- RD1  out  32  read data, port 1.
- RD2  out  32  read data, port 2.
- RegWriteW  out  1  qualified write enable (for hazard and forwarding logic).
- WriteDataW  out  32  final write-back value (for forwarding).
- RetiredCnt  out  CNT_W  count of non-bubble instructions that completed W.

Behaviour:
- Decode uses op=InstrW[31:26] and funct=InstrW[5:0].
- Source select:
  - lw/lb/lbu/lh/lhu (op 23/20/24/21/25 hex): extended load data.
  - jal (op 03), jalr (op 00, funct 09): PCouter8W.
  - mfhi (op 00, funct 10): HiDataW.
  - mflo (op 00, funct 12): LoDataW.
  - All other writers: ALUOutW.
- Load extension, with off=ALUOutW[1:0]:
  - lb/lbu select byte ReadDataW[8*off+7 : 8*off]; lb sign-extends, lbu zero-extends.
  - lh/lhu select halfword ReadDataW[16*off[1]+15 : 16*off[1]], ignoring off[0]; lh sign-extends, lhu zero-extends.
  - lw passes the word unmodified.
- Writer classes: R-type except jr/mult/multu/div/divu/mthi/mtlo/syscall, plus I-type ALU ops, lui, loads, jal.
- RegWriteW = writer class AND WriteRegW != 0 AND condition.
  - Condition: movnW requires RtDataW != 0; movzW requires RtDataW == 0; otherwise 1.
  - movnW and movzW both high is illegal, and no write occurs.
- Commit: at the rising edge, if RegWriteW, GPR[WriteRegW] <= WriteDataW. Latency is one edge.
- $0 reads 0 and is never written.
- Read ports are combinational with write-through:
  - If RegWriteW and A1 == WriteRegW != 0, RD1 = WriteDataW; otherwise the stored value.
  - RD2 follows the same rule on A2.
  - Both ports may hit the same register in the same cycle.
- RetiredCnt increments by 1 at each edge where InstrW != 0, including squashed MOVN/MOVZ.
  - Wraps from all-ones to 0.
  - Unaffected by read ports.
- Reset (reset == 0, asynchronous):
  - All GPRs clear to 0, except $28 = GP_INIT and $29 = SP_INIT.
  - RetiredCnt clears to 0.
  - Combinational outputs follow the inputs immediately; a write in flight during reset assertion is discarded.
  - The first commit occurs at the first rising edge after reset deasserts.
- A bubble (InstrW == 0) decodes as sll $0 and produces no write.

Decomposition:
- Shared package (mips_defs), used by decode and control elsewhere:
  - opcode/funct localparams: OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_JAL, OP_RTYPE, FN_JALR, FN_MFHI, FN_MFLO, FN_JR, FN_MULT, FN_DIV, etc.
  - Register-number constants: REG_ZERO, REG_GP, REG_SP, REG_RA.
- Sub-module load_ext: combinational byte/halfword select and extension, ports (ReadDataW, off, op) -> ext data; independently testable.
- Write-source mux, write qualification, GPR array and counter live in the top module.

Test Plan:
- Reset low, then release; read $28, $29, $5 -> 32'h1800, 32'h2FFC, 0; RetiredCnt = 0.
- lb to $8 with ReadDataW = 32'h1234_80FF, off = 1 -> $8 = 32'hFFFF_FF80. Same case with lbu -> 32'h0000_0080. lh with off = 2 -> 32'h0000_1234.
- jal (WriteRegW = 31, PCouter8W = 32'h3008) with A1 = 31 in the same cycle -> RD1 = 32'h3008 before the edge (write-through); $31 = 32'h3008 after the edge.
- movn $9 with RtDataW = 0 -> RegWriteW = 0 and $9 unchanged, RetiredCnt +1. Repeat with RtDataW = 5, ALUOutW = 32'hAB -> $9 = 32'hAB.
- addu to $0 with ALUOutW = 32'hDEAD -> RegWriteW = 0, RD1(A1 = 0) = 0. Bubble -> no write, RetiredCnt unchanged.
- Counter preloaded to all-ones via a long run (or a reduced CNT_W = 4 build, 16 instructions) -> wraps to 0. Assert reset mid-run -> counter and GPRs reset immediately, without waiting for clk.
